// File: rtl/transmitter_pc2.sv
// transmitter_pc2: device-side PS/2-style frame sender for the keyboard simulator.
// Takes one scancode per valid/ready handshake and shifts out an 11-bit frame
// (start 0, data LSB first, odd parity, stop 1) on PC2_DATA. The serial clock
// PC2_CLK is divided down from clk. Data only changes while PC2_CLK is high, so
// a receiver that samples on the PC2_CLK falling edge always sees settled bits.
// A host inhibit aborts the frame and triggers an automatic retransmit.
module transmitter_pc2 #(
  parameter int CLK_DIV  = 2500,
  parameter int IDLE_GAP = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       inhibit,
  output logic       PC2_CLK,
  output logic       PC2_DATA,
  output logic       busy,
  output logic       tx_done
);

  // One serial bit lasts two half-periods of PC2_CLK.
  localparam int BIT_CYC = 2 * CLK_DIV;
  // Idle time after a frame or abort. At least one cycle, so the GAP state
  // always has a defined exit even if no idle bit periods are requested.
  localparam int GAP_RAW = IDLE_GAP * BIT_CYC;
  localparam int GAP_CYC = (GAP_RAW < 1) ? 1 : GAP_RAW;
  localparam int CNT_W   = $clog2(BIT_CYC);
  localparam int GAP_W   = $clog2(GAP_CYC + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_FALL = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LOW  = CNT_W'(CLK_DIV);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
  localparam logic [3:0]       BIT_STOP = 4'd10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [7:0]       byte_q, byte_d;
  logic             retx_q, retx_d;
  logic             clk_q, clk_d;
  logic             data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [10:0]      frame_w;
  logic [3:0]       next_bit_w;
  logic             abort_w;

  // Frame image indexed by bit number: bit 0 is start, bit 10 is stop.
  assign frame_w    = {1'b1, ~^byte_q, byte_q, 1'b0};
  assign next_bit_w = bit_q + 4'd1;

  // Once the stop bit's low phase has begun the frame is committed, so an
  // inhibit from that point on is ignored and the frame completes normally.
  assign abort_w = inhibit && !((bit_q == BIT_STOP) && (cnt_q >= CNT_LOW));

  assign tx_ready = (state_q == ST_IDLE) && !inhibit && !rst;
  assign PC2_CLK  = clk_q;
  assign PC2_DATA = data_q;
  assign busy     = busy_q;
  assign tx_done  = done_q;

  // Next-state logic: handshake in IDLE, bit timing in SEND, idle/retransmit in GAP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    byte_d  = byte_q;
    retx_d  = retx_q;
    clk_d   = clk_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tx_valid && tx_ready) begin
          byte_d  = tx_data;
          state_d = ST_SEND;
          cnt_d   = '0;
          bit_d   = 4'd0;
          clk_d   = 1'b1;
          data_d  = 1'b0;
          busy_d  = 1'b1;
          retx_d  = 1'b0;
        end
      end

      ST_SEND: begin
        if (abort_w) begin
          state_d = ST_GAP;
          gap_d   = '0;
          clk_d   = 1'b1;
          data_d  = 1'b1;
          retx_d  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          clk_d = 1'b1;
          if (bit_q == BIT_STOP) begin
            state_d = ST_GAP;
            gap_d   = '0;
            data_d  = 1'b1;
            done_d  = 1'b1;
            retx_d  = 1'b0;
          end else begin
            bit_d  = next_bit_w;
            data_d = frame_w[next_bit_w];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_FALL) begin
            clk_d = 1'b0;
          end
        end
      end

      ST_GAP: begin
        clk_d  = 1'b1;
        data_d = 1'b1;
        if (gap_q != GAP_LAST) begin
          gap_d = gap_q + 1'b1;
        end else if (retx_q) begin
          // Aborted frame: resend the held byte once the host lets go.
          if (!inhibit) begin
            state_d = ST_SEND;
            cnt_d   = '0;
            bit_d   = 4'd0;
            data_d  = 1'b0;
            retx_d  = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        clk_d   = 1'b1;
        data_d  = 1'b1;
      end
    endcase
  end

  // State registers with synchronous reset; reset truncates any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= 4'd0;
      gap_q   <= '0;
      byte_q  <= 8'h00;
      retx_q  <= 1'b0;
      clk_q   <= 1'b1;
      data_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      byte_q  <= byte_d;
      retx_q  <= retx_d;
      clk_q   <= clk_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule
